// File: rtl/std_cache_pkg.sv
// std_cache_pkg: shared scheduler index type and AXI ID to requester decode
package std_cache_pkg;
  localparam int unsigned num_req_default = 3;
  localparam int unsigned sched_idx_w = $clog2(num_req_default);
  typedef logic [sched_idx_w-1:0] sched_idx_t;
  localparam logic [3:0] axi_id_icache = 4'b0000;
  localparam logic [3:0] axi_id_dcache = 4'b0111;
  localparam logic [3:0] axi_id_bypass = 4'b1000;
  localparam sched_idx_t req_icache = 2'd0;
  localparam sched_idx_t req_bypass = 2'd1;
  localparam sched_idx_t req_dcache = 2'd2;
  // Bypass owns every ID with the top bit set (4'b1???)
  function automatic sched_idx_t id_to_req(input logic [3:0] id);
    return id[3] ? req_bypass : (id == axi_id_dcache ? req_dcache : req_icache);
  endfunction
endpackage

// File: rtl/fifo_v3.sv
// fifo_v3: small power-of-two FIFO; push while full is accepted when a pop happens in the same cycle
module fifo_v3 #(
  parameter int unsigned DATA_WIDTH = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);
  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AddrW-1:0] r_wp, r_rp;
  logic [AddrW:0] r_cnt;
  logic w_push, w_pop;
  assign full_o = r_cnt == (AddrW+1)'(DEPTH);
  assign empty_o = r_cnt == '0;
  assign w_pop = pop_i & ~empty_o;
  assign w_push = push_i & (~full_o | w_pop);
  assign data_o = r_mem[r_rp];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      r_cnt <= r_cnt + (AddrW+1)'(w_push) - (AddrW+1)'(w_pop);
      r_wp <= r_wp + AddrW'(w_push);
      r_rp <= r_rp + AddrW'(w_pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wp] <= data_i;
  end
endmodule

// File: rtl/std_axi_sched_arb.sv
// std_axi_sched_arb: one-channel arbiter with eligibility masking and grant lock
// STD_AXI_SCHED_RR_EN selects round-robin; otherwise the highest eligible index wins
module std_axi_sched_arb
  import std_cache_pkg::*;
#(
  parameter int unsigned N = 3,
  localparam int unsigned IdxW = $clog2(N)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N-1:0]    i_valid,
  input  logic [N-1:0]    i_elig,
  input  logic            i_ready,
  output logic            o_valid,
  output logic [IdxW-1:0] o_sel,
  output logic [N-1:0]    o_ready,
  output logic            o_hs,
  output logic            o_locked
);
  logic [N-1:0] w_req;
  logic [IdxW-1:0] w_win, r_sel;
  logic r_lock;
  assign w_req = i_valid & i_elig;
`ifdef STD_AXI_SCHED_RR_EN
  logic [IdxW-1:0] r_ptr;
  int w_idx;
  // Scan downward in offset so the requester closest to the pointer wins
  always_comb begin
    w_win = '0;
    w_idx = 0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      w_idx = (int'(r_ptr) + k) % int'(N);
      if (w_req[w_idx]) w_win = IdxW'(w_idx);
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_ptr <= '0;
    else if (o_hs) r_ptr <= (o_sel == IdxW'(N - 1)) ? '0 : o_sel + 1'b1;
  end
`else
  always_comb begin
    w_win = '0;
    for (int i = 0; i < int'(N); i++) if (w_req[i]) w_win = IdxW'(i);
  end
`endif
  // A locked grant is replayed regardless of stall, credits or new requests
  assign o_valid = r_lock | (|w_req);
  assign o_sel = r_lock ? r_sel : w_win;
  assign o_hs = o_valid & i_ready;
  assign o_ready = o_hs ? {{(N-1){1'b0}}, 1'b1} << o_sel : '0;
  assign o_locked = r_lock;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lock <= 1'b0;
      r_sel <= '0;
    end else begin
      r_lock <= o_valid & ~i_ready;
      r_sel <= o_sel;
    end
  end
endmodule

// File: rtl/std_axi_port_scheduler.sv
// std_axi_port_scheduler: shares one AXI4 master port among NumReq requesters with credits and W ordering
// STD_AXI_SCHED_RR_EN enables round-robin arbitration on AR and AW
module std_axi_port_scheduler
  import std_cache_pkg::*;
#(
  parameter int unsigned NumReq = 3,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned WFifoDepth = 4,
  localparam int unsigned IdxW = $clog2(NumReq)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              stall_i,
  input  logic [NumReq-1:0] ar_valid_i,
  output logic [NumReq-1:0] ar_ready_o,
  output logic              ar_valid_o,
  input  logic              ar_ready_i,
  output logic [IdxW-1:0]   ar_sel_o,
  input  logic [NumReq-1:0] aw_valid_i,
  output logic [NumReq-1:0] aw_ready_o,
  output logic              aw_valid_o,
  input  logic              aw_ready_i,
  output logic [IdxW-1:0]   aw_sel_o,
  output logic [IdxW-1:0]   w_sel_o,
  output logic              w_sel_valid_o,
  input  logic              w_last_hs_i,
  input  logic              r_done_i,
  input  logic [IdxW-1:0]   r_req_i,
  input  logic              b_done_i,
  input  logic [IdxW-1:0]   b_req_i,
  output logic              idle_o,
  output logic              err_o
);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  logic [CntW-1:0] r_rd_cnt [NumReq];
  logic [CntW-1:0] r_wr_cnt [NumReq];
  logic [NumReq-1:0] w_rd_ok, w_wr_ok, w_rd_inc, w_rd_dec, w_wr_inc, w_wr_dec, w_rd_zero, w_wr_zero;
  logic w_ar_hs, w_aw_hs, w_ar_lock, w_aw_lock, w_full, w_empty, w_uflow, r_err;
  logic [IdxW-1:0] w_head;
  always_comb begin
    w_rd_ok = '0;
    w_wr_ok = '0;
    w_rd_zero = '0;
    w_wr_zero = '0;
    for (int i = 0; i < int'(NumReq); i++) begin
      w_rd_zero[i] = r_rd_cnt[i] == '0;
      w_wr_zero[i] = r_wr_cnt[i] == '0;
      w_rd_ok[i] = !stall_i && r_rd_cnt[i] < CntW'(MaxOutstanding);
      w_wr_ok[i] = !stall_i && !w_full && r_wr_cnt[i] < CntW'(MaxOutstanding);
    end
  end
  always_comb begin
    w_rd_inc = '0;
    w_rd_dec = '0;
    w_wr_inc = '0;
    w_wr_dec = '0;
    for (int i = 0; i < int'(NumReq); i++) begin
      w_rd_inc[i] = w_ar_hs && ar_sel_o == IdxW'(i);
      w_rd_dec[i] = r_done_i && r_req_i == IdxW'(i);
      w_wr_inc[i] = w_aw_hs && aw_sel_o == IdxW'(i);
      w_wr_dec[i] = b_done_i && b_req_i == IdxW'(i);
    end
  end
  std_axi_sched_arb #(.N(NumReq)) u_ar_arb (
    .clk_i, .rst_ni, .i_valid(ar_valid_i), .i_elig(w_rd_ok), .i_ready(ar_ready_i),
    .o_valid(ar_valid_o), .o_sel(ar_sel_o), .o_ready(ar_ready_o), .o_hs(w_ar_hs), .o_locked(w_ar_lock)
  );
  std_axi_sched_arb #(.N(NumReq)) u_aw_arb (
    .clk_i, .rst_ni, .i_valid(aw_valid_i), .i_elig(w_wr_ok), .i_ready(aw_ready_i),
    .o_valid(aw_valid_o), .o_sel(aw_sel_o), .o_ready(aw_ready_o), .o_hs(w_aw_hs), .o_locked(w_aw_lock)
  );
  // An AW consumed by a W last in the same cycle while the FIFO is empty never enters it
  fifo_v3 #(.DATA_WIDTH(IdxW), .DEPTH(WFifoDepth)) u_w_fifo (
    .clk_i, .rst_ni, .full_o(w_full), .empty_o(w_empty), .data_i(aw_sel_o),
    .push_i(w_aw_hs & ~(w_empty & w_last_hs_i)), .data_o(w_head), .pop_i(w_last_hs_i & ~w_empty)
  );
  assign w_sel_valid_o = ~w_empty | w_aw_hs;
  assign w_sel_o = ~w_empty ? w_head : w_aw_hs ? aw_sel_o : '0;
  assign w_uflow = |(w_rd_dec & ~w_rd_inc & w_rd_zero) | |(w_wr_dec & ~w_wr_inc & w_wr_zero);
  assign idle_o = &w_rd_zero & &w_wr_zero & w_empty & ~w_ar_lock & ~w_aw_lock;
  assign err_o = r_err;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
      for (int i = 0; i < int'(NumReq); i++) begin
        r_rd_cnt[i] <= '0;
        r_wr_cnt[i] <= '0;
      end
    end else begin
      r_err <= r_err | w_uflow;
      for (int i = 0; i < int'(NumReq); i++) begin
        r_rd_cnt[i] <= r_rd_cnt[i] + CntW'(w_rd_inc[i] & ~w_rd_dec[i])
                       - CntW'(w_rd_dec[i] & ~w_rd_inc[i] & ~w_rd_zero[i]);
        r_wr_cnt[i] <= r_wr_cnt[i] + CntW'(w_wr_inc[i] & ~w_wr_dec[i])
                       - CntW'(w_wr_dec[i] & ~w_wr_inc[i] & ~w_wr_zero[i]);
      end
    end
  end
endmodule
